// File: rtl/i2c_pad_share_pkg.sv
// Shared types and defaults for the I2C_0 pad-sharing arbiter.
package i2c_pad_share_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StGrantMss = 2'd1,
    StGrantFab = 2'd2,
    StHoldoff  = 2'd3
  } state_e;

  typedef enum logic {
    OwnMss = 1'b0,
    OwnFab = 1'b1
  } owner_e;

  localparam int unsigned DefIdleCycles    = 64;
  localparam int unsigned DefTimeoutCycles = 65536;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes pad readback, detects START/STOP and tracks bus-busy.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sda_y_i,
  input  logic scl_y_i,
  input  logic force_clr_i,
  output logic sda_s_o,
  output logic scl_s_o,
  output logic start_o,
  output logic stop_o,
  output logic busy_o
);

  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic                   sda_prev_q;
  logic                   busy_q;

  assign sda_s_o = sda_sync_q[SYNC_STAGES-1];
  assign scl_s_o = scl_sync_q[SYNC_STAGES-1];
  assign start_o = sda_prev_q & ~sda_s_o & scl_s_o;
  assign stop_o  = ~sda_prev_q & sda_s_o & scl_s_o;
  assign busy_o  = busy_q;

  // Synchronizers reset to the released (high) level so reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sda_sync_q <= '1;
      scl_sync_q <= '1;
      sda_prev_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_y_i};
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_y_i};
      sda_prev_q <= sda_s_o;
      if (force_clr_i) begin
        busy_q <= 1'b0;
      end else if (start_o) begin
        busy_q <= 1'b1;
      end else if (stop_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2c_pad_share_arbiter.sv
// Arbitrates the I2C_0 pad pair between the MSS controller and a fabric master.
module i2c_pad_share_arbiter
  import i2c_pad_share_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned IDLE_CYCLES    = DefIdleCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned CNT_W          = 17
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_mss_i,
  input  logic req_fab_i,
  output logic gnt_mss_o,
  output logic gnt_fab_o,
  input  logic mss_sda_m2f_i,
  input  logic mss_sda_m2f_oe_i,
  input  logic mss_scl_m2f_i,
  input  logic mss_scl_m2f_oe_i,
  output logic mss_sda_f2m_o,
  output logic mss_scl_f2m_o,
  input  logic fab_sda_pull_i,
  input  logic fab_scl_pull_i,
  output logic fab_sda_in_o,
  output logic fab_scl_in_o,
  output logic pad_sda_d_o,
  output logic pad_scl_d_o,
  output logic pad_sda_e_o,
  output logic pad_scl_e_o,
  input  logic pad_sda_y_i,
  input  logic pad_scl_y_i,
  output logic bus_busy_o,
  output logic timeout_err_o
);

  state_e             state_q;
  owner_e             rr_last_q;
  logic               gnt_mss_q, gnt_fab_q, timeout_err_q;
  logic [CNT_W-1:0]   tmo_cnt_q, idle_cnt_q;
  logic               sda_s, scl_s, start, stop, busy;
  logic               in_grant, own_req, tmo_hit;
  owner_e             own;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_mon (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .sda_y_i    (pad_sda_y_i),
    .scl_y_i    (pad_scl_y_i),
    .force_clr_i(tmo_hit),
    .sda_s_o    (sda_s),
    .scl_s_o    (scl_s),
    .start_o    (start),
    .stop_o     (stop),
    .busy_o     (busy)
  );

  assign in_grant = (state_q == StGrantMss) || (state_q == StGrantFab);
  assign own      = (state_q == StGrantMss) ? OwnMss : OwnFab;
  assign own_req  = (state_q == StGrantMss) ? req_mss_i : req_fab_i;
  assign tmo_hit  = in_grant & busy & ~start & ~stop
                  & (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign pad_sda_d_o   = 1'b0;
  assign pad_scl_d_o   = 1'b0;
  assign pad_sda_e_o   = (gnt_mss_q & mss_sda_m2f_oe_i & ~mss_sda_m2f_i) | (gnt_fab_q & fab_sda_pull_i);
  assign pad_scl_e_o   = (gnt_mss_q & mss_scl_m2f_oe_i & ~mss_scl_m2f_i) | (gnt_fab_q & fab_scl_pull_i);
  assign mss_sda_f2m_o = gnt_mss_q ? sda_s : 1'b1;
  assign mss_scl_f2m_o = gnt_mss_q ? scl_s : 1'b1;
  assign fab_sda_in_o  = gnt_fab_q ? sda_s : 1'b1;
  assign fab_scl_in_o  = gnt_fab_q ? scl_s : 1'b1;
  assign gnt_mss_o     = gnt_mss_q;
  assign gnt_fab_o     = gnt_fab_q;
  assign bus_busy_o    = busy;
  assign timeout_err_o = timeout_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      rr_last_q     <= OwnFab;
      gnt_mss_q     <= 1'b0;
      gnt_fab_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
      idle_cnt_q    <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          tmo_cnt_q  <= '0;
          idle_cnt_q <= '0;
          if (busy) begin
            // A third-party master owns the bus; wait for its STOP.
            if (stop) state_q <= StHoldoff;
          end else if (!start) begin
            if (req_mss_i && (!req_fab_i || rr_last_q == OwnFab)) begin
              state_q   <= StGrantMss;
              gnt_mss_q <= 1'b1;
            end else if (req_fab_i) begin
              state_q   <= StGrantFab;
              gnt_fab_q <= 1'b1;
            end
          end
        end
        StGrantMss, StGrantFab: begin
          if (tmo_hit || (!own_req && (!busy || stop))) begin
            state_q       <= StHoldoff;
            gnt_mss_q     <= 1'b0;
            gnt_fab_q     <= 1'b0;
            rr_last_q     <= own;
            tmo_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            timeout_err_q <= tmo_hit;
          end else if (start || stop || !busy) begin
            tmo_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
        StHoldoff: begin
          // Bus-free window restarts on any low line or foreign traffic.
          if (busy || start || !(sda_s && scl_s)) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
            state_q    <= StIdle;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_pad_share_arbiter.sv
// Directed self-checking bench for i2c_pad_share_arbiter.
module tb_i2c_pad_share_arbiter;

  localparam int unsigned IdleCycles = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_mss = 1'b0, req_fab = 1'b0;
  logic gnt_mss, gnt_fab;
  logic mss_sda = 1'b1, mss_sda_oe = 1'b0, mss_scl = 1'b1, mss_scl_oe = 1'b0;
  logic mss_sda_f2m, mss_scl_f2m;
  logic fab_sda_pull = 1'b0, fab_scl_pull = 1'b0;
  logic fab_sda_in, fab_scl_in;
  logic pad_sda_d, pad_scl_d, pad_sda_e, pad_scl_e;
  logic ext_sda_pull = 1'b0, ext_scl_pull = 1'b0;
  logic pad_sda_y, pad_scl_y;
  logic bus_busy, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Open-drain wired-AND of the arbiter drive and any external master.
  assign pad_sda_y = ~(pad_sda_e | ext_sda_pull);
  assign pad_scl_y = ~(pad_scl_e | ext_scl_pull);

  always #5 clk = ~clk;

  i2c_pad_share_arbiter #(
    .SYNC_STAGES   (2),
    .IDLE_CYCLES   (IdleCycles),
    .TIMEOUT_CYCLES(100),
    .CNT_W         (17)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .req_mss_i       (req_mss),
    .req_fab_i       (req_fab),
    .gnt_mss_o       (gnt_mss),
    .gnt_fab_o       (gnt_fab),
    .mss_sda_m2f_i   (mss_sda),
    .mss_sda_m2f_oe_i(mss_sda_oe),
    .mss_scl_m2f_i   (mss_scl),
    .mss_scl_m2f_oe_i(mss_scl_oe),
    .mss_sda_f2m_o   (mss_sda_f2m),
    .mss_scl_f2m_o   (mss_scl_f2m),
    .fab_sda_pull_i  (fab_sda_pull),
    .fab_scl_pull_i  (fab_scl_pull),
    .fab_sda_in_o    (fab_sda_in),
    .fab_scl_in_o    (fab_scl_in),
    .pad_sda_d_o     (pad_sda_d),
    .pad_scl_d_o     (pad_scl_d),
    .pad_sda_e_o     (pad_sda_e),
    .pad_scl_e_o     (pad_scl_e),
    .pad_sda_y_i     (pad_sda_y),
    .pad_scl_y_i     (pad_scl_y),
    .bus_busy_o      (bus_busy),
    .timeout_err_o   (timeout_err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  initial begin
    // Reset values
    tick(2);
    check_eq("rst_gnt_mss", gnt_mss, 1'b0);
    check_eq("rst_gnt_fab", gnt_fab, 1'b0);
    check_eq("rst_sda_e", pad_sda_e, 1'b0);
    check_eq("rst_scl_e", pad_scl_e, 1'b0);
    check_eq("rst_sda_d", pad_sda_d, 1'b0);
    check_eq("rst_scl_d", pad_scl_d, 1'b0);
    check_eq("rst_busy", bus_busy, 1'b0);
    check_eq("rst_terr", timeout_err, 1'b0);
    check_eq("rst_mss_f2m", mss_sda_f2m, 1'b1);
    check_eq("rst_fab_in", fab_scl_in, 1'b1);
    reset = 1'b0;

    // Tie from reset goes to MSS, one cycle after the request
    req_mss = 1'b1; req_fab = 1'b1;
    tick(1);
    check_eq("tie0_gnt_mss", gnt_mss, 1'b1);
    check_eq("tie0_gnt_fab", gnt_fab, 1'b0);
    fab_sda_pull = 1'b1; #1;
    check_eq("nonowner_no_effect", pad_sda_e, 1'b0);
    fab_sda_pull = 1'b0;
    mss_scl_oe = 1'b1; mss_scl = 1'b0; #1;
    check_eq("mss_scl_drive", pad_scl_e, 1'b1);
    tick(2);
    check_eq("mss_scl_f2m_low", mss_scl_f2m, 1'b0);
    check_eq("fab_scl_in_masked", fab_scl_in, 1'b1);
    mss_scl_oe = 1'b0;
    tick(3);
    mss_sda_oe = 1'b1; mss_sda = 1'b0; #1;
    check_eq("mss_sda_drive", pad_sda_e, 1'b1);
    tick(3);
    check_eq("start_busy", bus_busy, 1'b1);
    mss_sda_oe = 1'b0;
    tick(3);
    check_eq("stop_idle", bus_busy, 1'b0);

    // MSS releases with bus idle; FAB after the bus-free hold-off
    req_mss = 1'b0;
    tick(1);
    check_eq("rel_mss", gnt_mss, 1'b0);
    tick(IdleCycles);
    check_eq("holdoff_edge_fab", gnt_fab, 1'b0);
    tick(1);
    check_eq("after_holdoff_fab", gnt_fab, 1'b1);

    // Tie after FAB served -> MSS
    req_fab = 1'b0;
    tick(1);
    check_eq("rel_fab", gnt_fab, 1'b0);
    req_mss = 1'b1; req_fab = 1'b1;
    tick(IdleCycles + 1);
    check_eq("rr_mss_gnt", gnt_mss, 1'b1);
    check_eq("rr_mss_nofab", gnt_fab, 1'b0);

    // Tie after MSS served -> FAB
    req_mss = 1'b0; req_fab = 1'b0;
    tick(1);
    req_mss = 1'b1; req_fab = 1'b1;
    tick(IdleCycles + 1);
    check_eq("rr_fab_gnt", gnt_fab, 1'b1);
    check_eq("rr_fab_nomss", gnt_mss, 1'b0);

    // Fabric frame: release request mid-byte, grant held until STOP
    fab_sda_pull = 1'b1; #1;
    check_eq("fab_sda_drive", pad_sda_e, 1'b1);
    tick(3);
    check_eq("fab_start_busy", bus_busy, 1'b1);
    check_eq("fab_sda_in_low", fab_sda_in, 1'b0);
    check_eq("mss_f2m_masked", mss_sda_f2m, 1'b1);
    fab_scl_pull = 1'b1; req_fab = 1'b0;
    tick(5);
    check_eq("hold_till_stop", gnt_fab, 1'b1);
    fab_scl_pull = 1'b0;
    tick(3);
    fab_sda_pull = 1'b0;
    tick(2);
    check_eq("stop_seen_still_gnt", gnt_fab, 1'b1);
    tick(1);
    check_eq("stop_drops_gnt", gnt_fab, 1'b0);
    check_eq("stop_clears_busy", bus_busy, 1'b0);
    tick(IdleCycles);
    check_eq("post_stop_holdoff", gnt_mss, 1'b0);
    tick(1);
    check_eq("post_stop_mss", gnt_mss, 1'b1);

    // Timeout: START then SCL stuck low
    mss_sda_oe = 1'b1; mss_sda = 1'b0;
    tick(3);
    check_eq("tmo_start_busy", bus_busy, 1'b1);
    mss_scl_oe = 1'b1; mss_scl = 1'b0;
    tick(99);
    check_eq("tmo_not_yet_gnt", gnt_mss, 1'b1);
    check_eq("tmo_not_yet_err", timeout_err, 1'b0);
    tick(1);
    check_eq("tmo_gnt", gnt_mss, 1'b0);
    check_eq("tmo_sda_e", pad_sda_e, 1'b0);
    check_eq("tmo_scl_e", pad_scl_e, 1'b0);
    check_eq("tmo_err", timeout_err, 1'b1);
    check_eq("tmo_busy", bus_busy, 1'b0);
    tick(1);
    check_eq("tmo_err_pulse", timeout_err, 1'b0);
    mss_sda_oe = 1'b0; mss_scl_oe = 1'b0;
    tick(80);
    check_eq("tmo_rearb", gnt_mss, 1'b1);
    req_mss = 1'b0;
    tick(70);

    // Third-party master: no grant until STOP plus hold-off, SCL glitch restarts it
    ext_sda_pull = 1'b1;
    tick(3);
    check_eq("ext_busy", bus_busy, 1'b1);
    req_fab = 1'b1;
    tick(10);
    check_eq("ext_no_gnt", gnt_fab, 1'b0);
    ext_sda_pull = 1'b0;
    tick(3);
    check_eq("ext_stop", bus_busy, 1'b0);
    tick(30);
    ext_scl_pull = 1'b1;
    tick(1);
    ext_scl_pull = 1'b0;
    tick(66);
    check_eq("glitch_restart", gnt_fab, 1'b0);
    tick(1);
    check_eq("glitch_gnt", gnt_fab, 1'b1);
    check_eq("fab_in_idle", fab_sda_in, 1'b1);

    // Reset during an MSS transfer
    req_fab = 1'b0;
    tick(71);
    req_mss = 1'b1;
    tick(1);
    check_eq("pre_rst_gnt", gnt_mss, 1'b1);
    mss_sda_oe = 1'b1; mss_sda = 1'b0;
    tick(3);
    check_eq("pre_rst_sda_e", pad_sda_e, 1'b1);
    check_eq("pre_rst_f2m", mss_sda_f2m, 1'b0);
    reset = 1'b1;
    tick(1);
    check_eq("mid_rst_sda_e", pad_sda_e, 1'b0);
    check_eq("mid_rst_gnt_mss", gnt_mss, 1'b0);
    check_eq("mid_rst_gnt_fab", gnt_fab, 1'b0);
    check_eq("mid_rst_busy", bus_busy, 1'b0);
    check_eq("mid_rst_f2m", mss_sda_f2m, 1'b1);
    mss_sda_oe = 1'b0;
    reset = 1'b0;
    tick(1);
    check_eq("post_rst_idle_gnt", gnt_mss, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
